// File: rtl/mem_reinit_pkg.sv
// Package: mem_reinit_pkg
// Shared definitions for the RAM readback path:
// - ADDR_W   : width of addresses and word counters
// - state_e  : sweep controller states
// - ptr_w / cnt_w : widths for FIFO pointers and occupancy counters
// - wrap_inc : modulo-depth address increment
package mem_reinit_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Pointer width for a buffer of 'depth' entries (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Counter width able to hold the values 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Next address, wrapping from depth-1 back to 0.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W-1:0] depth);
        return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/mem_readback_fifo.sv
// Module: mem_readback_fifo
// Small synchronous FIFO buffering words read back from RAM.
// Ports:
// - clk, reset   : clock, synchronous active-high reset
// - push_i       : write push_data_i at the end of this cycle
// - push_data_i  : entry to store ({last, data} in the readback path)
// - pop_i        : drop the head entry at the end of this cycle
// - head_o       : oldest stored entry
// - count_o      : current occupancy (0..DEPTH)
// Push and pop in the same cycle are both performed; the caller never
// pushes when full and never pops when empty.
module mem_readback_fifo
    import mem_reinit_pkg::*;
#(
    parameter int WID   = 10,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic [WID-1:0]          push_data_i,
    input  logic                    pop_i,
    output logic [WID-1:0]          head_o,
    output logic [cnt_w(DEPTH)-1:0] count_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WID-1:0] mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;

    // Storage, pointers and occupancy; reset clears contents so head reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mem_readback.sv
// Module: mem_readback
// Sweeps word_count words starting at start_addr (mod DEPTH_MEM) out of a
// block-RAM read port and presents them on a valid/ready stream.
// Ports:
// - clk, reset             : clock, synchronous active-high reset
// - start                  : 1-cycle request, honoured only when idle
// - start_addr, word_count : sweep parameters, sampled with start
// - raddr / rdata          : RAM read address (registered) and RAM dout
// - m_data/m_valid/m_ready/m_last : output stream, m_last on the final word
// - busy                   : sweep in progress
// - done                   : 1-cycle pulse after the final word handoff
// Reads are only issued when the FIFO is guaranteed room for them once they
// arrive (credit = occupancy + in-flight reads - this cycle's pop), so the
// RAM latency never causes a dropped word under backpressure.
module mem_readback
    import mem_reinit_pkg::*;
#(
    parameter int WID_MEM    = 9,
    parameter int DEPTH_MEM  = 2048,
    parameter int READ_LAT   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic [ADDR_W-1:0]  word_count,
    output logic [ADDR_W-1:0]  raddr,
    input  logic [WID_MEM-1:0] rdata,
    output logic [WID_MEM-1:0] m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               busy,
    output logic               done
);

    localparam int CW = cnt_w(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH_MEM);

    state_e              state_q;
    logic [ADDR_W-1:0]   raddr_q;
    logic [ADDR_W-1:0]   addr_q;      // next address to issue
    logic [ADDR_W-1:0]   count_q;     // words in this sweep
    logic [ADDR_W-1:0]   issued_q;    // words issued so far
    logic                busy_q;
    logic                done_q;
    logic [READ_LAT:0]   pipe_vld_q;  // one bit per in-flight read
    logic [READ_LAT:0]   pipe_last_q; // last-word tag travelling with it

    logic [CW-1:0]       fifo_count_s;
    logic [WID_MEM:0]    fifo_head_s;
    logic                pop_s;
    logic                push_s;
    logic [ADDR_W-1:0]   inflight_s;
    logic [ADDR_W-1:0]   credit_s;
    logic                issue_start_s;
    logic                issue_run_s;
    logic                issue_s;
    logic                issue_last_s;
    logic [ADDR_W-1:0]   issue_addr_s;
    logic [ADDR_W-1:0]   addr_d;
    logic                handoff_s;

    // Issue decision, credit check and next issue address.
    always_comb begin
        pop_s      = m_valid & m_ready;
        push_s     = pipe_vld_q[READ_LAT];
        handoff_s  = pop_s & m_last;
        inflight_s = '0;
        for (int i = 0; i <= READ_LAT; i++) begin
            inflight_s = inflight_s + ADDR_W'(pipe_vld_q[i]);
        end
        credit_s = ADDR_W'(fifo_count_s) + inflight_s - ADDR_W'(pop_s);
        // The first word goes out in the start cycle itself to save a cycle.
        issue_start_s = (state_q == IDLE) && start && (word_count != 32'd0);
        issue_run_s   = (state_q == RUN) && (issued_q < count_q) &&
                        (credit_s < ADDR_W'(FIFO_DEPTH));
        issue_s       = issue_start_s | issue_run_s;
        if (issue_start_s) begin
            issue_addr_s = start_addr % DEPTH_A;
            issue_last_s = (word_count == 32'd1);
        end else begin
            issue_addr_s = addr_q;
            issue_last_s = (issued_q == count_q - 32'd1);
        end
        addr_d = wrap_inc(issue_addr_s, DEPTH_A);
    end

    // Sweep FSM, counters, read address register and latency pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            raddr_q     <= '0;
            addr_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            done_q      <= 1'b0;
            pipe_vld_q  <= {pipe_vld_q[READ_LAT-1:0], issue_s};
            pipe_last_q <= {pipe_last_q[READ_LAT-1:0], issue_s & issue_last_s};
            if (issue_s) begin
                raddr_q <= issue_addr_s;
                addr_q  <= addr_d;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (word_count != 32'd0) begin
                            state_q  <= RUN;
                            busy_q   <= 1'b1;
                            count_q  <= word_count;
                            issued_q <= 32'd1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue_run_s) begin
                        issued_q <= issued_q + 32'd1;
                    end
                    if (handoff_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    mem_readback_fifo #(
        .WID   (WID_MEM + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_s),
        .push_data_i ({pipe_last_q[READ_LAT], rdata}),
        .pop_i       (pop_s),
        .head_o      (fifo_head_s),
        .count_o     (fifo_count_s)
    );

    assign m_valid = (fifo_count_s != '0);
    assign m_data  = fifo_head_s[WID_MEM-1:0];
    assign m_last  = fifo_head_s[WID_MEM];
    assign raddr   = raddr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mem_readback.sv
// Bench for mem_readback: behavioural RAM (READ_LAT=1, ram[i] = i & 9'h1FF),
// directed sweeps plus random sweeps with random backpressure, all checked
// against an expected word sequence computed from address arithmetic.
module tb_mem_readback;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] start_addr;
    logic [31:0] word_count;
    logic [31:0] raddr;
    logic [8:0]  rdata;
    logic [8:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] ram [2048];

    always #5 clk = ~clk;

    mem_readback dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .raddr      (raddr),
        .rdata      (rdata),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    // Behavioural RAM: one-cycle registered read.
    always @(posedge clk) rdata <= ram[raddr[10:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] exp_word(input logic [31:0] sa, input int k);
        logic [31:0] a;
        a = ((sa % 32'd2048) + 32'(k)) % 32'd2048;
        return a[8:0];
    endfunction

    function automatic logic pick_ready(input int pct);
        return ($urandom_range(99, 0) < pct);
    endfunction

    // One sweep. restart_cyc>=0 pulses start again at that cycle;
    // reset_after>=0 asserts reset once that many words were handed off.
    task automatic run_sweep(input logic [31:0] sa, input logic [31:0] cnt, input int pct,
                             input int restart_cyc, input int reset_after);
        int idx = 0, done_n = 0, first_v = -1, handoff_cyc = -1, rst_phase = 0;
        int limit;
        bit finished = 0, held = 0, busy_seen = 0;
        logic [8:0] hold_d;
        logic hold_l;
        limit = 40 + 20 * int'(cnt);
        @(posedge clk); #1;
        start = 1'b1; start_addr = sa; word_count = cnt; m_ready = pick_ready(pct);
        for (int cyc = 0; cyc < limit && !finished; cyc++) begin
            @(negedge clk);
            if (rst_phase == 2) begin
                check("rst_valid", 32'(m_valid), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_raddr", raddr, 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_words", 32'(idx), 32'(reset_after));
                check("rst_done_n", 32'(done_n), 32'd0);
                finished = 1;
            end else if (rst_phase == 0) begin
                if (held) begin
                    check("hold_valid", 32'(m_valid), 32'd1);
                    check("hold_data", 32'(m_data), 32'(hold_d));
                    check("hold_last", 32'(m_last), 32'(hold_l));
                end
                if (m_valid && first_v < 0) first_v = cyc;
                if (busy) busy_seen = 1;
                if (cyc == 1) check("busy_start", 32'(busy), 32'(cnt != 32'd0));
                if (done) begin
                    done_n++;
                    check("done_time", 32'(cyc), (cnt == 32'd0) ? 32'd1 : 32'(handoff_cyc + 1));
                end
                if (m_valid && m_ready) begin
                    check("data", 32'(m_data), 32'(exp_word(sa, idx)));
                    check("last", 32'(m_last), 32'(32'(idx) == cnt - 32'd1));
                    if (32'(idx) == cnt - 32'd1) handoff_cyc = cyc;
                    idx++;
                end
                held = m_valid && !m_ready;
                hold_d = m_data;
                hold_l = m_last;
                if (cnt == 32'd0 && cyc >= 5) finished = 1;
                if (handoff_cyc >= 0 && cyc >= handoff_cyc + 2) finished = 1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc + 1 == restart_cyc) begin
                start = 1'b1; start_addr = 32'd500; word_count = 32'd3;
            end
            m_ready = pick_ready(pct);
            if (rst_phase == 1) begin
                reset = 1'b0; rst_phase = 2;
            end else if (rst_phase == 0 && reset_after >= 0 && idx == reset_after) begin
                reset = 1'b1; rst_phase = 1;
            end
        end
        if (!finished) check("timeout", 32'd0, 32'd1);
        if (reset_after < 0) begin
            check("word_total", 32'(idx), cnt);
            check("done_count", 32'(done_n), 32'd1);
            check("busy_end", 32'(busy), 32'd0);
            if (cnt == 32'd0) begin
                check("zero_valid", 32'(first_v), 32'hFFFF_FFFF);
                check("zero_busy", 32'(busy_seen), 32'd0);
            end else begin
                check("first_valid", 32'(first_v), 32'd3);
                if (pct >= 100) check("throughput", 32'(handoff_cyc), 32'(2 + int'(cnt)));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 9'(i & 9'h1FF);
        reset = 1'b1; start = 1'b0; start_addr = '0; word_count = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_raddr", raddr, 32'd0);
        check("reset_valid", 32'(m_valid), 32'd0);
        check("reset_data", 32'(m_data), 32'd0);
        check("reset_last", 32'(m_last), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b0;

        run_sweep(32'd0, 32'd8, 100, -1, -1);
        run_sweep(32'd2045, 32'd5, 100, -1, -1);
        run_sweep(32'd0, 32'd16, 30, -1, -1);
        run_sweep(32'd0, 32'd0, 100, -1, -1);
        run_sweep(32'd0, 32'd10, 100, 2, -1);
        run_sweep(32'd0, 32'd10, 100, -1, 3);
        run_sweep(32'd0, 32'd2, 100, -1, -1);
        run_sweep(32'd5000, 32'd6, 60, -1, -1);
        for (int r = 0; r < 4; r++) begin
            run_sweep($urandom, 32'($urandom_range(40, 1)), int'($urandom_range(100, 20)), -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
